// File: rtl/doubly_linked_list.sv
// Doubly linked list store behind a simple command port: push/insert/delete/read
// on a register array of nodes with head/tail tracking and a length count.
module doubly_linked_list #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_NODE   = 8,
    localparam int ADDR_WIDTH = $clog2(MAX_NODE + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [2:0]            op,
    input  logic                  op_start,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ADDR_WIDTH-1:0] next_node_addr,
    output logic [ADDR_WIDTH-1:0] pre_node_addr,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic                  op_done,
    output logic                  fault,
    output logic [ADDR_WIDTH-1:0] head,
    output logic [ADDR_WIDTH-1:0] tail,
    output logic [ADDR_WIDTH-1:0] length,
    output logic                  full,
    output logic                  empty
);
    localparam int IDX_W = (MAX_NODE > 1) ? $clog2(MAX_NODE) : 1;
    localparam logic [ADDR_WIDTH-1:0] NULL_A = '1;
    localparam logic [ADDR_WIDTH-1:0] MAX_A  = ADDR_WIDTH'(MAX_NODE);
    localparam logic [ADDR_WIDTH-1:0] ONE_A  = ADDR_WIDTH'(1);

    localparam logic [2:0] OP_READ = 3'd0, OP_INSERT = 3'd1, OP_PUSH_BACK = 3'd2,
                           OP_PUSH_FRONT = 3'd3, OP_DEL_ADDR = 3'd4, OP_DEL_VALUE = 3'd5;

    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_FIND, S_DONE, S_FAULT} state_t;

    function automatic logic [IDX_W-1:0] ix(input logic [ADDR_WIDTH-1:0] a);
        return a[IDX_W-1:0];
    endfunction

    state_t                state_reg, state_next;
    logic [DATA_WIDTH-1:0] data_mem [MAX_NODE];
    logic [ADDR_WIDTH-1:0] next_mem [MAX_NODE];
    logic [ADDR_WIDTH-1:0] prev_mem [MAX_NODE];
    logic [MAX_NODE-1:0]   valid_reg;
    logic [MAX_NODE-1:0]   node_free;
    logic [ADDR_WIDTH-1:0] head_reg, tail_reg, length_reg, cur_reg;
    logic [ADDR_WIDTH-1:0] addr_out_reg, next_out_reg, prev_out_reg;
    logic [DATA_WIDTH-1:0] data_out_reg, cmd_data_reg;
    logic [ADDR_WIDTH-1:0] cmd_addr_reg;
    logic [2:0]            cmd_op_reg;
    logic                  op_done_reg, fault_reg;

    logic [ADDR_WIDTH-1:0] free_addr, del_addr, del_prev, del_next, ins_prev;
    logic                  addr_ok, reject, find_match, del_go;

    genvar gi;
    generate
        for (gi = 0; gi < MAX_NODE; gi++) begin : g_free
            assign node_free[gi] = ~valid_reg[gi];
        end
    endgenerate

    // Lowest free slot wins, so scan downward and let the last hit stand.
    always_comb begin
        free_addr = '0;
        for (int i = MAX_NODE - 1; i >= 0; i--) begin
            if (node_free[i]) free_addr = ADDR_WIDTH'(i);
        end
    end

    always_comb begin
        addr_ok = (addr_in < MAX_A) && valid_reg[ix(addr_in)];
        reject  = 1'b0;
        case (op)
            OP_READ, OP_DEL_ADDR: reject = !addr_ok;
            OP_INSERT:            reject = !addr_ok || full;
            OP_PUSH_BACK,
            OP_PUSH_FRONT:        reject = full;
            OP_DEL_VALUE:         reject = empty;
            default:              reject = 1'b1;
        endcase
    end

    always_comb begin
        find_match = (cur_reg != NULL_A) && (data_mem[ix(cur_reg)] == cmd_data_reg);
        del_go     = ((state_reg == S_EXEC) && (cmd_op_reg == OP_DEL_ADDR)) ||
                     ((state_reg == S_FIND) && find_match);
        del_addr   = (state_reg == S_FIND) ? cur_reg : cmd_addr_reg;
        del_prev   = prev_mem[ix(del_addr)];
        del_next   = next_mem[ix(del_addr)];
        ins_prev   = prev_mem[ix(cmd_addr_reg)];
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (op_start) begin
                    if (reject)                  state_next = S_FAULT;
                    else if (op == OP_DEL_VALUE) state_next = S_FIND;
                    else                         state_next = S_EXEC;
                end
            end
            S_EXEC:  state_next = S_DONE;
            S_FIND: begin
                if (cur_reg == NULL_A) state_next = S_FAULT;
                else if (find_match)   state_next = S_DONE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= S_IDLE;
            valid_reg    <= '0;
            for (int i = 0; i < MAX_NODE; i++) begin
                data_mem[i] <= '0;
                next_mem[i] <= NULL_A;
                prev_mem[i] <= NULL_A;
            end
            head_reg     <= NULL_A;
            tail_reg     <= NULL_A;
            length_reg   <= '0;
            cur_reg      <= NULL_A;
            addr_out_reg <= NULL_A;
            next_out_reg <= NULL_A;
            prev_out_reg <= NULL_A;
            data_out_reg <= '0;
            cmd_data_reg <= '0;
            cmd_addr_reg <= '0;
            cmd_op_reg   <= '0;
            op_done_reg  <= 1'b0;
            fault_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            op_done_reg <= (state_next == S_DONE) || (state_next == S_FAULT);
            fault_reg   <= (state_next == S_FAULT);
            case (state_reg)
                S_IDLE: begin
                    if (op_start) begin
                        cmd_op_reg   <= op;
                        cmd_addr_reg <= addr_in;
                        cmd_data_reg <= data_in;
                        cur_reg      <= head_reg;
                    end
                end
                S_EXEC: begin
                    case (cmd_op_reg)
                        OP_READ: begin
                            data_out_reg <= data_mem[ix(cmd_addr_reg)];
                            next_out_reg <= next_mem[ix(cmd_addr_reg)];
                            prev_out_reg <= prev_mem[ix(cmd_addr_reg)];
                            addr_out_reg <= cmd_addr_reg;
                        end
                        OP_PUSH_BACK: begin
                            valid_reg[ix(free_addr)] <= 1'b1;
                            data_mem[ix(free_addr)]  <= cmd_data_reg;
                            next_mem[ix(free_addr)]  <= NULL_A;
                            prev_mem[ix(free_addr)]  <= tail_reg;
                            if (tail_reg == NULL_A) head_reg <= free_addr;
                            else next_mem[ix(tail_reg)] <= free_addr;
                            tail_reg     <= free_addr;
                            length_reg   <= length_reg + ONE_A;
                            addr_out_reg <= free_addr;
                        end
                        OP_PUSH_FRONT: begin
                            valid_reg[ix(free_addr)] <= 1'b1;
                            data_mem[ix(free_addr)]  <= cmd_data_reg;
                            next_mem[ix(free_addr)]  <= head_reg;
                            prev_mem[ix(free_addr)]  <= NULL_A;
                            if (head_reg == NULL_A) tail_reg <= free_addr;
                            else prev_mem[ix(head_reg)] <= free_addr;
                            head_reg     <= free_addr;
                            length_reg   <= length_reg + ONE_A;
                            addr_out_reg <= free_addr;
                        end
                        OP_INSERT: begin
                            valid_reg[ix(free_addr)]   <= 1'b1;
                            data_mem[ix(free_addr)]    <= cmd_data_reg;
                            next_mem[ix(free_addr)]    <= cmd_addr_reg;
                            prev_mem[ix(free_addr)]    <= ins_prev;
                            prev_mem[ix(cmd_addr_reg)] <= free_addr;
                            if (ins_prev == NULL_A) head_reg <= free_addr;
                            else next_mem[ix(ins_prev)] <= free_addr;
                            length_reg   <= length_reg + ONE_A;
                            addr_out_reg <= free_addr;
                        end
                        default: ;
                    endcase
                end
                S_FIND: begin
                    if (cur_reg != NULL_A && !find_match) cur_reg <= next_mem[ix(cur_reg)];
                end
                default: ;
            endcase
            // Unlink shared by DELETE_ADDR and a DELETE_VALUE hit; neighbours never alias del_addr.
            if (del_go) begin
                if (del_prev == NULL_A) head_reg <= del_next;
                else next_mem[ix(del_prev)] <= del_next;
                if (del_next == NULL_A) tail_reg <= del_prev;
                else prev_mem[ix(del_next)] <= del_prev;
                valid_reg[ix(del_addr)] <= 1'b0;
                data_mem[ix(del_addr)]  <= '0;
                next_mem[ix(del_addr)]  <= NULL_A;
                prev_mem[ix(del_addr)]  <= NULL_A;
                length_reg   <= length_reg - ONE_A;
                data_out_reg <= data_mem[ix(del_addr)];
                next_out_reg <= del_next;
                prev_out_reg <= del_prev;
                addr_out_reg <= del_addr;
            end
        end
    end

    assign data_out       = data_out_reg;
    assign next_node_addr = next_out_reg;
    assign pre_node_addr  = prev_out_reg;
    assign addr_out       = addr_out_reg;
    assign op_done        = op_done_reg;
    assign fault          = fault_reg;
    assign head           = head_reg;
    assign tail           = tail_reg;
    assign length         = length_reg;
    assign full           = (length_reg == MAX_A);
    assign empty          = (length_reg == '0);
endmodule

// File: doc/doubly_linked_list.md
Name: doubly_linked_list

Overview:
- Parametrised successor to the team's singly linked list.
- Holds up to MAX_NODE nodes in a register array; each node has data, next and prev pointers.
- Adds insert-before-address, delete-by-address, bidirectional pointer outputs and a length count.
- Sits behind a command port (op/op_start/op_done) as the list store for schedulers and free-list managers.

Parameters:
- DATA_WIDTH, 8, node payload width.
- MAX_NODE, 8, node capacity (≥2).
- ADDR_WIDTH, $clog2(MAX_NODE+1), localparam, not overridable. All-ones address = NULL.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- data_in  in  DATA_WIDTH  payload for push/insert, or value for delete
- addr_in  in  ADDR_WIDTH  node address for read/insert/delete_addr
- op  in  3  0 READ_ADDR, 1 INSERT_AT_ADDR, 2 PUSH_BACK, 3 PUSH_FRONT, 4 DELETE_ADDR, 5 DELETE_VALUE, 6/7 reserved
- op_start  in  1  command strobe, sampled only in IDLE
- data_out  out  DATA_WIDTH  data read or deleted
- next_node_addr  out  ADDR_WIDTH  next pointer of accessed node
- pre_node_addr  out  ADDR_WIDTH  prev pointer of accessed node
- addr_out  out  ADDR_WIDTH  address written/accessed
- op_done  out  1  one-cycle completion pulse
- fault  out  1  valid with op_done; operation rejected
- head  out  ADDR_WIDTH  head address
- tail  out  ADDR_WIDTH  tail address
- length  out  ADDR_WIDTH  valid node count
- full  out  1  length==MAX_NODE
- empty  out  1  length==0

Behaviour:
- Reset (rst low, async):
  - All nodes invalid; data cleared; next/prev = NULL.
  - head = tail = NULL; length = 0; data_out = 0.
  - next_node_addr, pre_node_addr, addr_out = NULL.
  - op_done = fault = 0; state = IDLE.
  - Reset mid-operation aborts the operation; no partial link state survives.
- States:
  - IDLE → EXEC (single-cycle ops), FIND (DELETE_VALUE), or FAULT.
  - EXEC → DONE → IDLE.
  - FIND loops one node per cycle → DONE on match, FAULT on NULL.
  - FAULT → IDLE.
- op_done is registered:
  - high exactly one cycle, in DONE or FAULT; fault is high only alongside op_done.
  - op_start outside IDLE is ignored.
- Timing: command accepted at the edge ending cycle N.
  - All single-cycle ops: op_done in cycle N+2.
  - DELETE_VALUE matching at position p (head=0): op_done in cycle N+p+2.
- Free-slot allocation: lowest-index invalid node, index 0 included.
- PUSH_BACK / PUSH_FRONT:
  - New node linked at tail/head; length+1; addr_out = new address.
  - On empty list, head = tail = new address, with both pointers NULL.
- INSERT_AT_ADDR: new node placed before addr_in.
  - If addr_in == head, the new node becomes head.
- DELETE_ADDR: unlink node addr_in and invalidate it; length-1.
  - head/tail update if the deleted node was an endpoint.
  - Deleting the last node gives head = tail = NULL.
  - data_out = deleted data.
- DELETE_VALUE: walks from head; removes the first match only, as DELETE_ADDR.
- READ_ADDR: data_out, next_node_addr, pre_node_addr from addr_in; list unchanged.
- Output updates:
  - data_out, next_node_addr, pre_node_addr and addr_out update only on successful READ_ADDR, DELETE_ADDR or DELETE_VALUE.
  - Push and insert update addr_out only.
- Fault conditions (list, head, tail, length and data_out unchanged):
  - push/insert when full;
  - addr_in ≥ MAX_NODE or node invalid (read, insert, delete_addr);
  - delete on empty list;
  - value not found;
  - op 6/7.
- Pointer invariants after every op:
  - node[x].next == y iff node[y].prev == x;
  - head.prev = NULL; tail.next = NULL.

Test Plan:
- Reset, then PUSH_BACK 0x11, 0x22, 0x33:
  - addr_out 0, 1, 2; head=0, tail=2, length=3.
  - READ_ADDR 1 → data_out 0x22, next 2, prev 0; op_done at N+2.
- PUSH_FRONT 0xAA on that list:
  - addr_out=3, head=3.
  - READ_ADDR 3 → next 0, prev NULL.
- DELETE_VALUE 0x33 on list AA,11,22,33 (p=3):
  - op_done at N+5; tail=1; length=3; data_out=0x33.
- INSERT_AT_ADDR addr 0, data 0x55: new node at slot 2, between 3 and 0.
  - DELETE_ADDR 3 → head=2, node 2 prev NULL.
- Fill to MAX_NODE=8, then PUSH_BACK:
  - fault=1 with op_done; full=1; length=8; head/tail unchanged.
  - DELETE_VALUE 0xEE (absent) → fault at N+10.
- Assert rst during a DELETE_VALUE walk:
  - immediate empty=1, head=NULL, op_done=0.
  - Subsequent PUSH_BACK lands in slot 0.
